// File: rtl/imem_fetch_queue.sv
// Prefetching instruction fetch unit: sequential imem requests buffered as {pc, inst} in a FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise fetch_misaligned.
module imem_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     res_n,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                     fetch_misaligned,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]    state_q;
  logic [31:0]   pc_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];

  logic          pop;
  logic [31:0]   redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          misaligned_q;
  logic          redirect_misaligned;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redirect_target     = redirect_pc;
  assign fetch_misaligned    = misaligned_q;
`else
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
`endif

  // Request decision uses the registered count, so a full queue never pushes even when popping.
  always_comb begin
    imem_req   = (state_q == FETCH) && (count_q < CW'(DEPTH)) && !redirect_valid;
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    inst_data  = mem_data_q[rptr_q];
    inst_pc    = mem_pc_q[rptr_q];
    fifo_count = count_q;
    pop        = inst_valid && inst_ready && !redirect_valid;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      pc_q    <= redirect_target;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q      <= redirect_misaligned ? HALT : FETCH;
      misaligned_q <= redirect_misaligned;
`else
      state_q <= FETCH;
`endif
    end else begin
      if (state_q == BOOT) begin
        state_q <= FETCH;
      end
      if (imem_req) begin
        mem_data_q[wptr_q] <= imem_data;
        mem_pc_q[wptr_q]   <= pc_q;
        wptr_q             <= wptr_q + PW'(1);
        pc_q               <= pc_q + 32'd4;
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      unique case ({imem_req, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Directed table-driven bench for imem_fetch_queue with hand sequences for reset, backpressure
// and misaligned redirects.
module tb_imem_fetch_queue;

  logic        clk;
  logic        res_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int checks = 0;
  int errors = 0;

  imem_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .res_n          (res_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .fifo_count     (fifo_count)
  );

  // Instruction memory model: word derived from its address.
  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(logic ready, logic rv, logic [31:0] rpc, logic req,
                              logic [31:0] addr, logic valid, logic [31:0] pc, logic [2:0] cnt);
    vec_t v;
    v.ready = ready; v.rv = rv; v.rpc = rpc; v.exp_req = req;
    v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int pushes;

  initial begin
    //           ready rv  rpc            req addr           v   pc             cnt
    vecs[0]  = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          3'd0);
    vecs[1]  = mk(1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          3'd0);
    vecs[2]  = mk(1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          3'd1);
    vecs[3]  = mk(1, 0, 32'h0,          1, 32'h8,          1, 32'h4,          3'd1);
    vecs[4]  = mk(1, 0, 32'h0,          1, 32'hC,          1, 32'h8,          3'd1);
    vecs[5]  = mk(0, 0, 32'h0,          1, 32'h10,         1, 32'hC,          3'd1);
    vecs[6]  = mk(0, 0, 32'h0,          1, 32'h14,         1, 32'hC,          3'd2);
    vecs[7]  = mk(0, 0, 32'h0,          1, 32'h18,         1, 32'hC,          3'd3);
    vecs[8]  = mk(0, 0, 32'h0,          0, 32'h1C,         1, 32'hC,          3'd4);
    vecs[9]  = mk(1, 0, 32'h0,          0, 32'h1C,         1, 32'hC,          3'd4);
    vecs[10] = mk(1, 0, 32'h0,          1, 32'h1C,         1, 32'h10,         3'd3);
    vecs[11] = mk(1, 1, 32'h40,         0, 32'h20,         1, 32'h14,         3'd3);
    vecs[12] = mk(1, 0, 32'h0,          1, 32'h40,         0, 32'h0,          3'd0);
    vecs[13] = mk(1, 0, 32'h0,          1, 32'h44,         1, 32'h40,         3'd1);
    vecs[14] = mk(1, 1, 32'hFFFF_FFF8,  0, 32'h48,         1, 32'h44,         3'd1);
    vecs[15] = mk(0, 0, 32'h0,          1, 32'hFFFF_FFF8,  0, 32'h0,          3'd0);
    vecs[16] = mk(0, 0, 32'h0,          1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFF8,  3'd1);
    vecs[17] = mk(0, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFF8,  3'd2);
    vecs[18] = mk(1, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFF8,  3'd3);
    vecs[19] = mk(1, 0, 32'h0,          1, 32'h8,          1, 32'hFFFF_FFFC,  3'd3);
    vecs[20] = mk(1, 0, 32'h0,          1, 32'hC,          1, 32'h0,          3'd3);
    vecs[21] = mk(1, 1, 32'h100,        0, 32'h10,         1, 32'h4,          3'd3);
    vecs[22] = mk(1, 1, 32'h200,        0, 32'h100,        0, 32'h0,          3'd0);
    vecs[23] = mk(1, 0, 32'h0,          1, 32'h200,        0, 32'h0,          3'd0);
    vecs[24] = mk(1, 0, 32'h0,          1, 32'h204,        1, 32'h200,        3'd1);

    res_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    check("rst_req",   {31'b0, imem_req},   32'h0);
    check("rst_addr",  imem_addr,           32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_data",  inst_data,           32'h0);
    check("rst_pc",    inst_pc,             32'h0);
    check("rst_cnt",   32'(fifo_count),     32'h0);

    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      inst_ready     = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_req", i),   {31'b0, imem_req},   {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d_cnt", i),   32'(fifo_count),     32'(vecs[i].exp_cnt));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i),   inst_pc,   vecs[i].exp_pc);
        check($sformatf("v%0d_data", i), inst_data, vecs[i].exp_pc ^ 32'hA5A5_0000);
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // Two entries queued, then asynchronous reset between clock edges.
    inst_ready = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_cnt", 32'(fifo_count), 32'd2);
    res_n = 1'b0;
    #1;
    check("async_valid", {31'b0, inst_valid}, 32'h0);
    check("async_cnt",   32'(fifo_count),     32'h0);
    check("async_addr",  imem_addr,           32'h0);
    check("async_req",   {31'b0, imem_req},   32'h0);

    // Backpressure from reset: exactly DEPTH pushes, then stall.
    @(negedge clk);
    res_n  = 1'b1;
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (imem_req) pushes++;
      @(negedge clk);
    end
    #1;
    check("bp_pushes", 32'(pushes),         32'd4);
    check("bp_cnt",    32'(fifo_count),     32'd4);
    check("bp_addr",   imem_addr,           32'h10);
    check("bp_req",    {31'b0, imem_req},   32'h0);
    @(negedge clk);
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_pc%0d", k),   inst_pc,   32'(4 * k));
      check($sformatf("bp_data%0d", k), inst_data, 32'(4 * k) ^ 32'hA5A5_0000);
      @(negedge clk);
    end

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    #1;
    check("mis_req0", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("halt_flag%0d", h),  {31'b0, fetch_misaligned}, 32'h1);
      check($sformatf("halt_req%0d", h),   {31'b0, imem_req},         32'h0);
      check($sformatf("halt_valid%0d", h), {31'b0, inst_valid},       32'h0);
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h44;
    #1;
    check("unhalt_req0", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("unhalt_flag", {31'b0, fetch_misaligned}, 32'h0);
    check("unhalt_req",  {31'b0, imem_req},         32'h1);
    check("unhalt_addr", imem_addr,                 32'h44);
    @(negedge clk);
    #1;
    check("unhalt_pc", inst_pc, 32'h44);
`else
    #1;
    check("mis_req",  {31'b0, imem_req}, 32'h1);
    check("mis_addr", imem_addr,         32'h40);
    @(negedge clk);
    #1;
    check("mis_valid", {31'b0, inst_valid}, 32'h1);
    check("mis_pc",    inst_pc,             32'h40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
